// File: rtl/tiny16_pkg.sv
// Shared tiny16 definitions: opcodes, sequencer state encoding and instruction fields.
// Holds constants and field-extract helpers only, so it has no latency or flow control.
package tiny16_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_MOV = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_LDI = 4'h7;
    localparam logic [3:0] OP_LD  = 4'h8;
    localparam logic [3:0] OP_ST  = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_JZ  = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ST_BOOT  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_MEM   = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS_MSB  = 8;
    localparam int RS_LSB  = 6;
    localparam int IMM_MSB = 8;
    localparam int IMM_LSB = 0;

    function automatic logic [3:0] ir_op(input logic [15:0] ir);
        return ir[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [2:0] ir_rd(input logic [15:0] ir);
        return ir[RD_MSB:RD_LSB];
    endfunction

    function automatic logic [2:0] ir_rs(input logic [15:0] ir);
        return ir[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [8:0] ir_imm9(input logic [15:0] ir);
        return ir[IMM_MSB:IMM_LSB];
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Memory request/acknowledge bus between the sequencer (master) and memory (slave).
// Request is held by the master until the slave acknowledges it.
interface control_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/tiny16_alu.sv
// Combinational tiny16 datapath: MOV/ADD/SUB/AND/OR/XOR/LDI result plus zero flag.
// Zero latency, no flow control.
module tiny16_alu
    import tiny16_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [8:0]  imm9,
    output logic [15:0] result,
    output logic        zero
);

    always_comb begin
        result = 16'h0000;
        case (op)
            OP_MOV:  result = b;
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_LDI:  result = {7'b0, imm9};
            default: result = 16'h0000;
        endcase
        zero = (result == 16'h0000);
    end

endmodule

// File: rtl/control_unit.sv
// tiny16 fetch/decode/execute sequencer driving the register file write port; 2 cycles
// per ALU/LDI/JMP/NOP, 3 per LD/ST with zero-wait memory; FETCH and MEM stall until mem_ack.
module control_unit
    import tiny16_pkg::*;
#(
    parameter bit ILLEGAL_HALTS = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    control_unit_if.master       mem,
    output logic [2:0]           src_sel,
    output logic [2:0]           dst_sel,
    output logic                 in_en,
    output logic [15:0]          in,
    output logic                 pc_inc,
    input  logic [15:0]          src,
    input  logic [15:0]          dst,
    output logic                 halted,
    output logic                 illegal
);

    logic [2:0]  state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic        z_q, z_d;

    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [15:0] alu_result;
    logic        alu_zero;

    assign op = ir_op(ir_q);
    assign rd = ir_rd(ir_q);
    assign rs = ir_rs(ir_q);

    tiny16_alu u_alu (
        .op     (op),
        .a      (dst),
        .b      (src),
        .imm9   (ir_imm9(ir_q)),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // All outputs decode from the current state, so an async reset idles them immediately.
    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        z_d           = z_q;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = 16'h0000;
        mem.mem_wdata = 16'h0000;
        src_sel       = 3'd0;
        dst_sel       = 3'd0;
        in_en         = 1'b0;
        in            = 16'h0000;
        pc_inc        = 1'b0;
        halted        = 1'b0;
        illegal       = 1'b0;

        case (state_q)
            ST_BOOT: state_d = ST_FETCH;

            ST_FETCH: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = src;
                if (mem.mem_ack) begin
                    ir_d    = mem.mem_rdata;
                    pc_inc  = 1'b1;
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                src_sel = rs;
                dst_sel = rd;
                state_d = ST_FETCH;
                case (op)
                    OP_NOP: ;
                    OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDI: begin
                        in_en = 1'b1;
                        in    = alu_result;
                        if (op != OP_MOV && op != OP_LDI) z_d = alu_zero;
                    end
                    OP_JMP, OP_JZ: begin
                        dst_sel = 3'd0;
                        if (op == OP_JMP || z_q) begin
                            in_en = 1'b1;
                            in    = src;
                        end
                    end
                    OP_LD, OP_ST: state_d = ST_MEM;
                    OP_HLT:       state_d = ST_HALT;
                    default: begin
                        illegal = 1'b1;
                        state_d = ILLEGAL_HALTS ? ST_HALT : ST_FETCH;
                    end
                endcase
            end

            ST_MEM: begin
                src_sel       = rs;
                dst_sel       = rd;
                mem.mem_req   = 1'b1;
                mem.mem_addr  = src;
                mem.mem_we    = (op == OP_ST);
                mem.mem_wdata = (op == OP_ST) ? dst : 16'h0000;
                if (mem.mem_ack) begin
                    if (op == OP_LD) begin
                        in_en = 1'b1;
                        in    = mem.mem_rdata;
                    end
                    state_d = ST_FETCH;
                end
            end

            ST_HALT: halted = 1'b1;

            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_BOOT;
            ir_q    <= 16'h0000;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            z_q     <= z_d;
        end
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Fetch/decode/execute sequencer for the tiny16 core; sits directly upstream of the register file and drives its `src_sel`, `dst_sel`, `in_en`, `in` and `pc_inc`.
- Register 0 is the program counter. The block fetches instruction words from memory at `src` (with `src_sel`=0) over a req/ack handshake.
- It decodes each instruction, computes ALU/immediate/jump results, and writes them back through the register file's write port.
- It performs LD/ST data accesses over the same memory handshake.

Parameters:
- ILLEGAL_HALTS, 0, when 1 a reserved opcode (C–E) halts the core instead of executing as NOP.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- mem_req  out  1  memory request; held until acknowledged.
- mem_we  out  1  1 = write, 0 = read; valid while `mem_req`.
- mem_addr  out  16  memory address; valid while `mem_req`.
- mem_wdata  out  16  store data; valid while `mem_req` && `mem_we`.
- mem_rdata  in  16  read data; sampled in the `mem_ack` cycle.
- mem_ack  in  1  request accepted/completed this cycle.
- src_sel  out  3  register file source select.
- dst_sel  out  3  register file destination select.
- in_en  out  1  register file write enable.
- in  out  16  register file write data.
- pc_inc  out  1  increment register 0.
- src  in  16  register file source read data (combinational from `src_sel`).
- dst  in  16  register file destination read data (combinational from `dst_sel`).
- halted  out  1  core stopped by HLT or illegal opcode.
- illegal  out  1  one-cycle pulse on decode of opcode C–E.

Behaviour:
- Instruction format:
  - opcode = `ir[15:12]`, rd = `ir[11:9]`, rs = `ir[8:6]`, imm9 = `ir[8:0]`.
- Opcodes:
  - 0 NOP.
  - 1 MOV rd<=rs.
  - 2 ADD rd<=rd+rs.
  - 3 SUB rd<=rd-rs.
  - 4 AND.
  - 5 OR.
  - 6 XOR.
  - 7 LDI rd<=zext(imm9).
  - 8 LD rd<=mem[rs].
  - 9 ST mem[rs]<=rd.
  - A JMP r0<=rs.
  - B JZ if Z then r0<=rs.
  - C–E reserved.
  - F HLT.
- Arithmetic: 16-bit, wraps modulo 2^16, no carry/overflow.
- Z flag: updated only by opcodes 2–6, Z = (result==16'h0000).
- States: BOOT, FETCH, EXEC, MEM, HALT.
- Reset (rst low, asynchronous):
  - state=BOOT, ir=0, Z=0.
  - All outputs 0: `mem_req`, `mem_we`, `in_en`, `pc_inc`, `halted`, `illegal`, `mem_addr`, `mem_wdata`, `in`, `src_sel`, `dst_sel`.
  - Reset mid-transaction drops `mem_req` immediately; any in-flight ack is discarded.
- BOOT: outputs idle; go to FETCH on the next clock.
- FETCH:
  - Drive `src_sel`=0, `mem_req`=1, `mem_we`=0, `mem_addr`=`src`.
  - On the `mem_ack` cycle: ir<=`mem_rdata`, `pc_inc`=1 for that cycle only, then go to EXEC.
  - Without ack: stay, with outputs stable.
- EXEC:
  - Drive `src_sel`=rs, `dst_sel`=rd.
  - Opcodes 1–7: `in_en`=1, `in`=result, then FETCH.
  - JMP: `dst_sel`=0, `in_en`=1, `in`=`src`, then FETCH.
  - JZ: same as JMP when Z=1; otherwise no write. Then FETCH.
  - LD/ST: go to MEM.
  - NOP: go to FETCH.
  - HLT: go to HALT.
  - Reserved: `illegal`=1 for one cycle, then HALT if ILLEGAL_HALTS else FETCH.
- MEM:
  - Drive `src_sel`=rs, `dst_sel`=rd, `mem_req`=1, `mem_addr`=`src`, `mem_we`=(op==ST), `mem_wdata`=`dst`.
  - On ack: for LD, `in_en`=1 and `in`=`mem_rdata`. Then go to FETCH.
- HALT: `halted`=1, no requests; leave only via reset.
- Exclusivity:
  - `in_en` and `pc_inc` are never asserted in the same cycle.
  - `pc_inc` is asserted only in the FETCH ack cycle.
  - The r0 increment therefore precedes any EXEC write to r0. Writes to r0 by MOV/LDI/LD act as jumps.
- Handshake:
  - `mem_req` deasserts the cycle after the ack cycle unless the next state also requests.
  - `mem_ack` while `mem_req`=0 is ignored.
  - A same-cycle ack is legal.
- Latency, zero-wait memory:
  - ALU/LDI/JMP/NOP: 2 cycles.
  - LD/ST: 3 cycles.

Decomposition:
- tiny16_pkg holds:
  - opcode localparams (OP_NOP..OP_HLT).
  - state encoding.
  - instruction field bit positions.
- Sub-module tiny16_alu is combinational and natural to split out:
  - Inputs: op, a=`dst`, b=`src`, imm9.
  - Outputs: result[15:0], zero.

Test Plan:
1. Reset release with mem returning 16'h7A05 (LDI r5,5) with zero-wait ack: first `mem_req` with `mem_addr`=0 occurs the cycle after BOOT; next cycle `in_en`=1, `dst_sel`=5, `in`=16'h0005; `pc_inc` pulses exactly once.
2. Program LDI r2,3; LDI r3,3; SUB r2,r3 (16'h34C0); JZ r4 (16'hB100) with r4 loaded to 16'h0020: r2 becomes 0, Z=1, and the next fetch address is 16'h0020.
3. ST r2→mem[r3] with ack delayed 4 cycles: `mem_req`, `mem_we`=1, `mem_addr`, and `mem_wdata` stay stable across all wait cycles; `in_en` stays 0.
4. LD r6,[r1] with `mem_rdata`=16'hBEEF: `in_en`=1 with `dst_sel`=6 and `in`=16'hBEEF in the ack cycle.
5. Opcode 16'hC000 with ILLEGAL_HALTS=1: `illegal` pulses 1 cycle, then `halted`=1 and no further `mem_req`. With ILLEGAL_HALTS=0, fetch resumes at the next address.
6. Assert rst low while FETCH is waiting for ack: `mem_req` drops in the same cycle; after release, the fetch restarts at address 0 via BOOT.
